// File: rtl/scara_move_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : scara_move_sequencer
// Description : Queues two-axis SCARA move commands and sequences each one
//               through the axis drivers. Each move runs load (settle), a
//               one-clock load strobe, arm, run, and done. Abort flushes the
//               command queue and returns the sequencer to idle.
// Revision    : 1.0 - initial release
// ============================================================================
module scara_move_sequencer #(
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 10
) (
    input  logic                          clk_50,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [7:0]                    cmd_steps_a,
    input  logic [7:0]                    cmd_steps_b,
    input  logic                          cmd_dir_a,
    input  logic                          cmd_dir_b,
    input  logic [15:0]                   cmd_scale,
    input  logic                          abort,
    output logic [7:0]                    num_steps_a,
    output logic [7:0]                    num_steps_b,
    output logic                          direction_a,
    output logic                          direction_b,
    output logic [15:0]                   step_scale,
    output logic                          new_in_a,
    output logic                          new_in_b,
    output logic                          enable_a,
    output logic                          enable_b,
    input  logic                          finished_a,
    input  logic                          finished_b,
    output logic                          busy,
    output logic                          move_done,
    output logic                          abort_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int c_aw = $clog2(FIFO_DEPTH);
    localparam int c_cw = c_aw + 1;

    localparam logic [c_cw-1:0] c_depth     = c_cw'(FIFO_DEPTH);
    localparam logic [c_cw-1:0] c_cnt_one   = c_cw'(1);
    localparam logic [c_aw-1:0] c_ptr_one   = c_aw'(1);
    localparam logic [7:0]      c_settle_ld = 8'(SETTLE_CYCLES - 1);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_load  = 3'd1;
    localparam logic [2:0] c_st_pulse = 3'd2;
    localparam logic [2:0] c_st_arm   = 3'd3;
    localparam logic [2:0] c_st_run   = 3'd4;
    localparam logic [2:0] c_st_done  = 3'd5;

    // Command queue storage: {steps_a, dir_a, steps_b, dir_b, scale}
    logic [33:0]     r_mem [FIFO_DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_cw-1:0] r_count;

    logic [2:0]      r_state;
    logic [7:0]      r_settle_cnt;
    logic            r_arm_cnt;
    // Set once the queue head has been moved into the output registers;
    // the following clock commits to LOAD.
    logic            r_loaded;
    logic            r_abort_prev;

    logic [7:0]      r_steps_a;
    logic [7:0]      r_steps_b;
    logic            r_dir_a;
    logic            r_dir_b;
    logic [15:0]     r_scale;
    logic            r_new_in;
    logic            r_enable;
    logic            r_move_done;
    logic            r_abort_done;

    logic            w_push;
    logic            w_pop;
    logic [33:0]     w_wr_data;

    assign cmd_ready = (r_count < c_depth) && !abort;
    assign w_push    = cmd_valid && cmd_ready;
    // The head is taken either while idle or on the exit of DONE, so
    // back-to-back moves see a single idle clock before the next LOAD.
    assign w_pop     = !abort && (r_count != '0) && !r_loaded &&
                       ((r_state == c_st_idle) || (r_state == c_st_done));
    assign w_wr_data = {cmd_steps_a, cmd_dir_a, cmd_steps_b, cmd_dir_b, cmd_scale};

    // Queue storage write; contents need no reset since count gates reads
    always_ff @(posedge clk_50) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_data;
        end
    end

    // Sequencer state machine, queue pointers and registered outputs
    always_ff @(posedge clk_50) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_settle_cnt <= '0;
            r_arm_cnt    <= 1'b0;
            r_loaded     <= 1'b0;
            r_abort_prev <= 1'b0;
            r_steps_a    <= '0;
            r_steps_b    <= '0;
            r_dir_a      <= 1'b0;
            r_dir_b      <= 1'b0;
            r_scale      <= '0;
            r_new_in     <= 1'b0;
            r_enable     <= 1'b0;
            r_move_done  <= 1'b0;
            r_abort_done <= 1'b0;
        end else begin
            r_new_in     <= 1'b0;
            r_move_done  <= 1'b0;
            r_abort_prev <= abort;
            r_abort_done <= abort && !r_abort_prev;

            if (abort) begin
                r_state  <= c_st_idle;
                r_enable <= 1'b0;
                r_loaded <= 1'b0;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_ptr_one;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_ptr_one;
                    {r_steps_a, r_dir_a, r_steps_b, r_dir_b, r_scale} <= r_mem[r_rd_ptr];
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + c_cnt_one;
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - c_cnt_one;
                end

                case (r_state)
                    c_st_idle: begin
                        if (r_loaded) begin
                            r_loaded     <= 1'b0;
                            r_settle_cnt <= c_settle_ld;
                            r_state      <= c_st_load;
                        end else if (w_pop) begin
                            r_loaded <= 1'b1;
                        end
                    end
                    c_st_load: begin
                        if (r_settle_cnt == 8'd0) begin
                            r_new_in <= 1'b1;
                            r_state  <= c_st_pulse;
                        end else begin
                            r_settle_cnt <= r_settle_cnt - 8'd1;
                        end
                    end
                    c_st_pulse: begin
                        r_enable  <= 1'b1;
                        r_arm_cnt <= 1'b0;
                        r_state   <= c_st_arm;
                    end
                    c_st_arm: begin
                        if (r_arm_cnt) begin
                            r_state <= c_st_run;
                        end else begin
                            r_arm_cnt <= 1'b1;
                        end
                    end
                    c_st_run: begin
                        if (finished_a && finished_b) begin
                            r_enable    <= 1'b0;
                            r_move_done <= 1'b1;
                            r_state     <= c_st_done;
                        end
                    end
                    c_st_done: begin
                        if (w_pop) begin
                            r_loaded <= 1'b1;
                        end
                        r_state <= c_st_idle;
                    end
                    default: begin
                        r_enable <= 1'b0;
                        r_state  <= c_st_idle;
                    end
                endcase
            end
        end
    end

    assign num_steps_a = r_steps_a;
    assign num_steps_b = r_steps_b;
    assign direction_a = r_dir_a;
    assign direction_b = r_dir_b;
    assign step_scale  = r_scale;
    assign new_in_a    = r_new_in;
    assign new_in_b    = r_new_in;
    assign enable_a    = r_enable;
    assign enable_b    = r_enable;
    assign move_done   = r_move_done;
    assign abort_done  = r_abort_done;
    assign fifo_count  = r_count;
    assign busy        = (r_state != c_st_idle) || (r_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_scara_move_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_scara_move_sequencer
// Description : Directed self-checking bench for scara_move_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scara_move_sequencer;

    localparam int FIFO_DEPTH    = 4;
    localparam int SETTLE_CYCLES = 10;

    logic        clk_50 = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_steps_a;
    logic [7:0]  cmd_steps_b;
    logic        cmd_dir_a;
    logic        cmd_dir_b;
    logic [15:0] cmd_scale;
    logic        abort;
    logic [7:0]  num_steps_a;
    logic [7:0]  num_steps_b;
    logic        direction_a;
    logic        direction_b;
    logic [15:0] step_scale;
    logic        new_in_a;
    logic        new_in_b;
    logic        enable_a;
    logic        enable_b;
    logic        finished_a;
    logic        finished_b;
    logic        busy;
    logic        move_done;
    logic        abort_done;
    logic [2:0]  fifo_count;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always #10 clk_50 = ~clk_50;

    scara_move_sequencer #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_dut (
        .clk_50     (clk_50),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_steps_a(cmd_steps_a),
        .cmd_steps_b(cmd_steps_b),
        .cmd_dir_a  (cmd_dir_a),
        .cmd_dir_b  (cmd_dir_b),
        .cmd_scale  (cmd_scale),
        .abort      (abort),
        .num_steps_a(num_steps_a),
        .num_steps_b(num_steps_b),
        .direction_a(direction_a),
        .direction_b(direction_b),
        .step_scale (step_scale),
        .new_in_a   (new_in_a),
        .new_in_b   (new_in_b),
        .enable_a   (enable_a),
        .enable_b   (enable_b),
        .finished_a (finished_a),
        .finished_b (finished_b),
        .busy       (busy),
        .move_done  (move_done),
        .abort_done (abort_done),
        .fifo_count (fifo_count)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_50);
        #1;
        cyc++;
    endtask

    task automatic push_cmd(input logic [7:0] sa, input logic da, input logic [7:0] sb,
                            input logic db, input logic [15:0] sc);
        cmd_steps_a = sa;
        cmd_dir_a   = da;
        cmd_steps_b = sb;
        cmd_dir_b   = db;
        cmd_scale   = sc;
        cmd_valid   = 1'b1;
        for (int k = 0; k < 100 && !cmd_ready; k++) tick();
        if (!cmd_ready) check_value("push_ready_timeout", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_new_in(input int bound, output int waited);
        waited = 0;
        while (!new_in_a && waited < bound) begin
            tick();
            waited++;
        end
        check_value("new_in_seen", 32'(new_in_a), 32'd1);
    endtask

    task automatic wait_move_done(input int bound);
        int w;
        w = 0;
        while (!move_done && w < bound) begin
            tick();
            w++;
        end
        check_value("move_done_seen", 32'(move_done), 32'd1);
    endtask

    initial begin
        int w;
        int en_cnt;
        int md_cnt;
        int first_en;
        int md_at;
        int done_cyc;
        int ni_cnt;

        reset       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_steps_a = '0;
        cmd_steps_b = '0;
        cmd_dir_a   = 1'b0;
        cmd_dir_b   = 1'b0;
        cmd_scale   = '0;
        abort       = 1'b0;
        finished_a  = 1'b0;
        finished_b  = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) tick();
        check_value("rst_steps_a", 32'(num_steps_a), 32'd0);
        check_value("rst_scale",   32'(step_scale),  32'd0);
        check_value("rst_enable",  32'(enable_a),    32'd0);
        check_value("rst_busy",    32'(busy),        32'd0);
        check_value("rst_count",   32'(fifo_count),  32'd0);
        reset = 1'b0;
        tick();
        check_value("post_rst_ready", 32'(cmd_ready), 32'd1);

        // ---------------- single move ----------------
        push_cmd(8'd5, 1'b1, 8'd3, 1'b0, 16'd256);
        check_value("single_count", 32'(fifo_count), 32'd1);
        check_value("single_busy",  32'(busy),       32'd1);
        wait_new_in(40, w);
        check_value("single_latency", 32'(w), 32'd12);
        check_value("single_new_in_b", 32'(new_in_b),    32'd1);
        check_value("single_steps_a",  32'(num_steps_a), 32'd5);
        check_value("single_dir_a",    32'(direction_a), 32'd1);
        check_value("single_steps_b",  32'(num_steps_b), 32'd3);
        check_value("single_dir_b",    32'(direction_b), 32'd0);
        check_value("single_scale",    32'(step_scale),  32'd256);
        check_value("single_en_pulse", 32'(enable_a),    32'd0);
        tick();
        check_value("arm_new_in",  32'(new_in_a), 32'd0);
        check_value("arm_en_a",    32'(enable_a), 32'd1);
        check_value("arm_en_b",    32'(enable_b), 32'd1);
        repeat (3) tick();
        check_value("run_wait_done", 32'(move_done), 32'd0);
        check_value("run_en",        32'(enable_a),  32'd1);
        finished_a = 1'b1;
        tick();
        check_value("run_only_a_done", 32'(move_done), 32'd0);
        finished_b = 1'b1;
        tick();
        check_value("done_pulse",  32'(move_done),   32'd1);
        check_value("done_en",     32'(enable_a),    32'd0);
        check_value("done_hold_a", 32'(num_steps_a), 32'd5);
        tick();
        check_value("done_clear",  32'(move_done),   32'd0);
        check_value("idle_busy",   32'(busy),        32'd0);
        check_value("idle_hold_s", 32'(step_scale),  32'd256);

        // ---------------- zero-step move, finished held high ----------------
        push_cmd(8'd0, 1'b0, 8'd0, 1'b0, 16'd1);
        en_cnt = 0; md_cnt = 0; first_en = -1; md_at = -1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (enable_a) begin
                en_cnt++;
                if (first_en < 0) first_en = i;
            end
            if (move_done) begin
                md_cnt++;
                md_at = i;
            end
        end
        check_value("zero_en_cycles",  32'(en_cnt),         32'd3);
        check_value("zero_done_count", 32'(md_cnt),         32'd1);
        check_value("zero_done_time",  32'(md_at - first_en), 32'd3);

        // ---------------- back-to-back, queue fills ----------------
        for (int i = 0; i < 5; i++)
            push_cmd(8'(10 + i), i[0], 8'(20 + i), ~i[0], 16'(100 * i));
        check_value("full_count", 32'(fifo_count), 32'd4);
        check_value("full_ready", 32'(cmd_ready),  32'd0);
        cmd_steps_a = 8'd99;
        cmd_valid   = 1'b1;
        repeat (2) tick();
        check_value("full_reject", 32'(fifo_count), 32'd4);
        cmd_valid = 1'b0;
        done_cyc = 0;
        for (int i = 0; i < 5; i++) begin
            wait_new_in(60, w);
            check_value("b2b_steps_a", 32'(num_steps_a), 32'(10 + i));
            check_value("b2b_steps_b", 32'(num_steps_b), 32'(20 + i));
            if (i > 0) check_value("b2b_gap", 32'(cyc - done_cyc), 32'd12);
            wait_move_done(20);
            done_cyc = cyc;
        end
        ni_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (new_in_a) ni_cnt++;
        end
        check_value("b2b_no_extra", 32'(ni_cnt), 32'd0);
        check_value("b2b_idle",     32'(busy),   32'd0);

        // ---------------- abort mid-RUN with two queued ----------------
        finished_a = 1'b0;
        finished_b = 1'b0;
        push_cmd(8'd7, 1'b0, 8'd8, 1'b1, 16'd50);
        push_cmd(8'd30, 1'b0, 8'd31, 1'b0, 16'd51);
        push_cmd(8'd40, 1'b1, 8'd41, 1'b1, 16'd52);
        w = 0;
        while (!enable_a && w < 40) begin
            tick();
            w++;
        end
        repeat (3) tick();
        check_value("abort_pre_en",    32'(enable_a),   32'd1);
        check_value("abort_pre_count", 32'(fifo_count), 32'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_value("abort_en",    32'(enable_b),   32'd0);
        check_value("abort_count", 32'(fifo_count), 32'd0);
        check_value("abort_done",  32'(abort_done), 32'd1);
        check_value("abort_busy",  32'(busy),       32'd0);
        tick();
        check_value("abort_done_clear", 32'(abort_done), 32'd0);
        ni_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (new_in_a) ni_cnt++;
        end
        check_value("abort_no_new_in", 32'(ni_cnt), 32'd0);

        // ---------------- cmd_valid together with abort ----------------
        cmd_steps_a = 8'd12;
        cmd_valid   = 1'b1;
        abort       = 1'b1;
        #1;
        check_value("va_ready", 32'(cmd_ready), 32'd0);
        tick();
        cmd_valid = 1'b0;
        abort     = 1'b0;
        check_value("va_count", 32'(fifo_count), 32'd0);
        check_value("va_abort_done", 32'(abort_done), 32'd1);
        check_value("va_busy",  32'(busy),       32'd0);

        // ---------------- reset during LOAD ----------------
        push_cmd(8'd21, 1'b1, 8'd22, 1'b1, 16'd777);
        push_cmd(8'd23, 1'b0, 8'd24, 1'b0, 16'd778);
        repeat (3) tick();
        check_value("load_steps_a", 32'(num_steps_a), 32'd21);
        reset = 1'b1;
        tick();
        check_value("rstload_steps_a", 32'(num_steps_a), 32'd0);
        check_value("rstload_dir_a",   32'(direction_a), 32'd0);
        check_value("rstload_scale",   32'(step_scale),  32'd0);
        check_value("rstload_count",   32'(fifo_count),  32'd0);
        check_value("rstload_busy",    32'(busy),        32'd0);
        reset = 1'b0;
        tick();
        check_value("rstload_ready", 32'(cmd_ready), 32'd1);
        push_cmd(8'd9, 1'b1, 8'd4, 1'b1, 16'd300);
        wait_new_in(40, w);
        check_value("after_rst_latency", 32'(w), 32'd12);
        check_value("after_rst_steps_a", 32'(num_steps_a), 32'd9);
        finished_a = 1'b1;
        finished_b = 1'b1;
        wait_move_done(20);
        tick();
        check_value("after_rst_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
